// File: rtl/enemy_update_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_pkg
//  Purpose  : Shared definitions for the enemy update sequencer.
//             - Enemy-table entry layout: [23:13] row, [12:1] col, [0] valid.
//             - Sequencer state encoding.
//             - Default movement, retirement and spawn constants.
//             - A helper that builds a valid entry.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package enemy_pkg;

  localparam int ENTRY_W   = 24;
  localparam int ADDR_W    = 6;
  localparam int ROW_HI    = 23;
  localparam int ROW_LO    = 13;
  localparam int COL_HI    = 12;
  localparam int COL_LO    = 1;
  localparam int VALID_BIT = 0;
  localparam int ROW_W     = ROW_HI - ROW_LO + 1;
  localparam int COL_W     = COL_HI - COL_LO + 1;
  localparam int CNT_W     = 7;   // holds 0..64

  localparam int               DEF_MOVE_STEP = 2;
  localparam int               DEF_ROW_LIMIT = 1200;
  localparam logic [ROW_W-1:0] DEF_SPAWN_ROW = 11'h080;
  localparam int               DEF_HIT_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MOVE  = 3'd2,
    ST_SPAWN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [ENTRY_W-1:0] entry_t;

  // Build a valid entry from its row and column fields.
  function automatic entry_t make_entry(input logic [ROW_W-1:0] row,
                                        input logic [COL_W-1:0] col);
    entry_t e;
    e                 = '0;
    e[ROW_HI:ROW_LO]  = row;
    e[COL_HI:COL_LO]  = col;
    e[VALID_BIT]      = 1'b1;
    return e;
  endfunction

endpackage : enemy_pkg
`default_nettype wire

// File: rtl/enemy_update_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_update_sequencer_if
//  Purpose  : Enemy-table RAM port bundle (one read port with 1-cycle latency,
//             one write port).
//  Signals  : rd_addr  - read address
//             rd_data  - RAM q, valid one cycle after rd_addr
//             wr_addr  - write address
//             wr_data  - write data
//             wren     - write enable, write happens on the clock edge
//  Modports : master - the sequencer; slave - the RAM
//  Revision : 1.0 - initial release
// ============================================================================
interface enemy_update_sequencer_if;
  import enemy_pkg::*;

  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               wren;

  modport master (output rd_addr, output wr_addr, output wr_data, output wren,
                  input  rd_data);
  modport slave  (input  rd_addr, input  wr_addr, input  wr_data, input  wren,
                  output rd_data);

endinterface : enemy_update_sequencer_if
`default_nettype wire

// File: rtl/enemy_update_sequencer_hit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hit_fifo
//  Purpose  : Small synchronous FIFO that queues destroyed-enemy slot
//             addresses until the next CLEAR pass.
//  Ports    : clock, reset (sync, active-low)
//             push/push_data  - enqueue, ignored when full
//             pop             - dequeue, ignored when empty
//             pop_data        - head of queue (valid when !empty)
//             full/empty      - status
//  Revision : 1.0 - initial release
// ============================================================================
module hit_fifo #(
  parameter int DEPTH = 4,   // at least 2
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  assign full     = (r_count == c_CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : hit_fifo
`default_nettype wire

// File: rtl/enemy_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_update_sequencer
//  Purpose  : Per-frame controller for the 64-entry enemy table. While calc is
//             low the display scanner owns the RAM read port; on a calc rising
//             edge the sequencer runs CLEAR (zero hit slots), MOVE (advance or
//             retire every valid enemy) and SPAWN (place one pending enemy in
//             the lowest free slot), then pulses frame_done.
//  Ports    : clock, reset (sync, active-low)
//             calc        - update window enable
//             scan_addr   - display read address
//             hit/hit_addr           - destroy-enemy pulse and slot
//             spawn_tick/spawn_col   - spawn request pulse and column
//             ram         - enemy RAM port (master)
//             busy        - a pass is running
//             frame_done  - one-cycle pulse on pass completion
//             enemy_count - valid entries after the last full MOVE pass
//             hit_overflow- sticky, a hit was dropped on a full queue
//  Revision : 1.0 - initial release
// ============================================================================
module enemy_update_sequencer
  import enemy_pkg::*;
#(
  parameter int               N_ENEMIES = 64,
  parameter int               MOVE_STEP = DEF_MOVE_STEP,
  parameter int               ROW_LIMIT = DEF_ROW_LIMIT,
  parameter logic [ROW_W-1:0] SPAWN_ROW = DEF_SPAWN_ROW,
  parameter int               HIT_DEPTH = DEF_HIT_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      calc,
  input  logic [ADDR_W-1:0]         scan_addr,
  input  logic                      hit,
  input  logic [ADDR_W-1:0]         hit_addr,
  input  logic                      spawn_tick,
  input  logic [COL_W-1:0]          spawn_col,
  enemy_update_sequencer_if.master  ram,
  output logic                      busy,
  output logic                      frame_done,
  output logic [CNT_W-1:0]          enemy_count,
  output logic                      hit_overflow
);

  localparam logic [2:0] c_IDLE  = ST_IDLE;
  localparam logic [2:0] c_CLEAR = ST_CLEAR;
  localparam logic [2:0] c_MOVE  = ST_MOVE;
  localparam logic [2:0] c_SPAWN = ST_SPAWN;
  localparam logic [2:0] c_DONE  = ST_DONE;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(N_ENEMIES - 1);

  logic [2:0]        r_state;
  logic              r_calc_q;
  logic [ADDR_W-1:0] r_idx;
  logic              r_phase;       // 0: address presented, 1: data returned
  logic [CNT_W-1:0]  r_count;
  logic              r_free_found;
  logic [ADDR_W-1:0] r_free_slot;
  logic              r_spawn_pending;
  logic [COL_W-1:0]  r_spawn_col;
  logic [CNT_W-1:0]  r_enemy_count;
  logic              r_hit_overflow;

  logic [ADDR_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic              w_valid;
  logic [ROW_W:0]    w_new_row;
  logic              w_retire;
  logic              w_keep;
  logic              w_act;
  logic              w_spawn_wr;

  hit_fifo #(
    .DEPTH (HIT_DEPTH),
    .WIDTH (ADDR_W)
  ) u_hit_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (hit),
    .push_data (hit_addr),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Every side effect of a pass is gated with calc so that the cycle in which
  // calc drops does nothing; the following cycle is already IDLE.
  assign w_pop      = (r_state == c_CLEAR) && calc && !w_empty;
  assign w_act      = (r_state == c_MOVE) && calc && r_phase;
  assign w_spawn_wr = (r_state == c_SPAWN) && calc && r_spawn_pending && r_free_found;

  assign w_row     = ram.rd_data[ROW_HI:ROW_LO];
  assign w_col     = ram.rd_data[COL_HI:COL_LO];
  assign w_valid   = ram.rd_data[VALID_BIT];
  // One extra bit so a row near 2047 cannot wrap below the limit.
  assign w_new_row = {1'b0, w_row} + (ROW_W + 1)'(MOVE_STEP);
  assign w_retire  = (w_new_row >= (ROW_W + 1)'(ROW_LIMIT));
  assign w_keep    = w_valid && !w_retire;

  always_comb begin
    ram.rd_addr = scan_addr;
    ram.wren    = 1'b0;
    ram.wr_addr = '0;
    ram.wr_data = '0;
    if (r_state == c_MOVE) begin
      ram.rd_addr = r_idx;
    end
    if (w_pop) begin
      ram.wren    = 1'b1;
      ram.wr_addr = w_head;
    end else if (w_act && w_valid) begin
      ram.wren    = 1'b1;
      ram.wr_addr = r_idx;
      ram.wr_data = w_retire ? '0 : make_entry(w_new_row[ROW_W-1:0], w_col);
    end else if (w_spawn_wr) begin
      ram.wren    = 1'b1;
      ram.wr_addr = r_free_slot;
      ram.wr_data = make_entry(SPAWN_ROW, r_spawn_col);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= c_IDLE;
      r_calc_q        <= 1'b0;
      r_idx           <= '0;
      r_phase         <= 1'b0;
      r_count         <= '0;
      r_free_found    <= 1'b0;
      r_free_slot     <= '0;
      r_spawn_pending <= 1'b0;
      r_spawn_col     <= '0;
      r_enemy_count   <= '0;
      r_hit_overflow  <= 1'b0;
    end else begin
      r_calc_q <= calc;

      if (hit && w_full) begin
        r_hit_overflow <= 1'b1;
      end

      // A fresh tick wins over consumption so a request is never lost.
      if (spawn_tick) begin
        r_spawn_pending <= 1'b1;
        r_spawn_col     <= spawn_col;
      end else if ((r_state == c_SPAWN) && calc) begin
        r_spawn_pending <= 1'b0;
      end

      case (r_state)
        c_IDLE: begin
          if (calc && !r_calc_q) begin
            r_state      <= c_CLEAR;
            r_idx        <= '0;
            r_phase      <= 1'b0;
            r_count      <= '0;
            r_free_found <= 1'b0;
            r_free_slot  <= '0;
          end
        end
        c_CLEAR: begin
          if (!calc) begin
            r_state <= c_IDLE;
          end else if (w_empty) begin
            r_state <= c_MOVE;
          end
        end
        c_MOVE: begin
          if (!calc) begin
            r_state <= c_IDLE;
          end else if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_keep) begin
              r_count <= r_count + CNT_W'(1);
            end
            // Ascending scan: the first empty or retired slot is the lowest.
            if (!w_keep && !r_free_found) begin
              r_free_found <= 1'b1;
              r_free_slot  <= r_idx;
            end
            if (r_idx == c_LAST) begin
              r_enemy_count <= r_count + {{(CNT_W - 1){1'b0}}, w_keep};
              r_state       <= c_SPAWN;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end
        end
        c_SPAWN: r_state <= calc ? c_DONE : c_IDLE;
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != c_IDLE);
  assign frame_done   = (r_state == c_DONE);
  assign enemy_count  = r_enemy_count;
  assign hit_overflow = r_hit_overflow;

endmodule : enemy_update_sequencer
`default_nettype wire

// File: tb/tb_enemy_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enemy_update_sequencer
//  Purpose  : Self-checking bench for enemy_update_sequencer. Holds the enemy
//             RAM, a behavioural frame model and a write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_update_sequencer;

  localparam int         STEP  = 2;
  localparam int         LIMIT = 1200;
  localparam int         QDEPTH = 4;
  localparam logic [10:0] SROW = 11'h080;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        calc = 1'b0;
  logic [5:0]  scan_addr = '0;
  logic        hit = 1'b0;
  logic [5:0]  hit_addr = '0;
  logic        spawn_tick = 1'b0;
  logic [11:0] spawn_col = '0;
  logic        busy;
  logic        frame_done;
  logic [6:0]  enemy_count;
  logic        hit_overflow;

  enemy_update_sequencer_if ram_if ();

  enemy_update_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .calc         (calc),
    .scan_addr    (scan_addr),
    .hit          (hit),
    .hit_addr     (hit_addr),
    .spawn_tick   (spawn_tick),
    .spawn_col    (spawn_col),
    .ram          (ram_if),
    .busy         (busy),
    .frame_done   (frame_done),
    .enemy_count  (enemy_count),
    .hit_overflow (hit_overflow)
  );

  always #5 clock = ~clock;

  // Enemy RAM with a bench backdoor write port.
  logic [23:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [23:0] bd_data = '0;

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_if.wren) begin
      mem[ram_if.wr_addr] <= ram_if.wr_data;
    end
    ram_if.rd_data <= mem[ram_if.rd_addr];
  end

  // Reference model state.
  typedef struct { logic [5:0] a; logic [23:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [23:0] ref_tab [64];
  int          hq[$];
  bit          m_ovf;
  bit          m_pend;
  logic [11:0] m_col;
  int          m_count;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Write monitor: every DUT write must be the next expected one.
  always @(negedge clock) begin
    wr_t e;
    if (reset && ram_if.wren) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: actual addr %0d data %h required no write",
                 ram_if.wr_addr, ram_if.wr_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(ram_if.wr_addr), 32'(e.a));
        check("write_data", 32'(ram_if.wr_data), 32'(e.d));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [23:0] ent(input int row, input int col);
    logic [10:0] r;
    logic [11:0] c;
    r = row[10:0];
    c = col[11:0];
    return {r, c, 1'b1};
  endfunction

  task automatic bd_write(input int a, input logic [23:0] d);
    bd_we   = 1'b1;
    bd_addr = a[5:0];
    bd_data = d;
    step();
    bd_we = 1'b0;
    ref_tab[a] = d;
  endtask

  task automatic do_hit(input int a);
    hit      = 1'b1;
    hit_addr = a[5:0];
    step();
    hit = 1'b0;
    if (hq.size() < QDEPTH) hq.push_back(a);
    else m_ovf = 1'b1;
  endtask

  task automatic do_spawn(input logic [11:0] col);
    spawn_tick = 1'b1;
    spawn_col  = col;
    step();
    spawn_tick = 1'b0;
    m_pend = 1'b1;
    m_col  = col;
  endtask

  task automatic push_exp(input int a, input logic [23:0] d);
    wr_t w;
    w.a = a[5:0];
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Frame rules: zero every queued hit, then walk n_proc entries moving or
  // retiring valid ones; a full walk also commits the count and the spawn.
  task automatic model_frame(input int n_proc, output int k);
    int a, nr, free, cnt;
    logic [23:0] e, nd;
    k = hq.size();
    while (hq.size() > 0) begin
      a = hq.pop_front();
      push_exp(a, 24'h0);
      ref_tab[a] = 24'h0;
    end
    free = -1;
    cnt  = 0;
    for (int i = 0; i < n_proc; i++) begin
      e = ref_tab[i];
      if (e[0]) begin
        nr = int'(e[23:13]) + STEP;
        if (nr >= LIMIT) begin
          push_exp(i, 24'h0);
          ref_tab[i] = 24'h0;
          if (free < 0) free = i;
        end else begin
          nd = ent(nr, int'(e[12:1]));
          push_exp(i, nd);
          ref_tab[i] = nd;
          cnt++;
        end
      end else if (free < 0) begin
        free = i;
      end
    end
    if (n_proc == 64) begin
      m_count = cnt;
      if (m_pend && free >= 0) begin
        nd = {SROW, m_col, 1'b1};
        push_exp(free, nd);
        ref_tab[free] = nd;
      end
      m_pend = 1'b0;
    end
  endtask

  task automatic cmp_table(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_tab[i]) bad++;
    check({tag, "_table_diffs"}, 32'(bad), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string tag);
    int k, c;
    bit seen;
    model_frame(64, k);
    calc = 1'b1;
    step();                       // now in the CLEAR entry cycle
    check({tag, "_busy_at_clear"}, 32'(busy), 32'd1);
    c = 0;
    seen = 0;
    while (c < 400 && !seen) begin
      if (frame_done) seen = 1;
      else begin
        step();
        c++;
      end
    end
    check({tag, "_done_cycle"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(k + 130));
    step();
    check({tag, "_done_pulse_len"}, 32'(frame_done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_enemy_count"}, 32'(enemy_count), 32'(m_count));
    calc = 1'b0;
    step();
    cmp_table(tag);
  endtask

  task automatic run_abort(input int idx);
    int k;
    bit seen;
    model_frame(idx, k);
    calc = 1'b1;
    step();
    repeat (k + 1 + 2 * idx) step();   // now presenting entry idx
    check("abort_busy_before", 32'(busy), 32'd1);
    calc = 1'b0;
    step();
    check("abort_busy_next", 32'(busy), 32'd0);
    seen = 0;
    repeat (140) begin
      if (frame_done) seen = 1;
      step();
    end
    check("abort_no_frame_done", 32'(seen), 32'd0);
    check("abort_enemy_count", 32'(enemy_count), 32'(m_count));
    scan_addr = 6'd37;
    #1;
    check("abort_rd_follows_scan", 32'(ram_if.rd_addr), 32'd37);
    cmp_table("abort");
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) if (ref_tab[i] != 24'h0) bd_write(i, 24'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_tab[i] = 24'h0;
    m_ovf = 0; m_pend = 0; m_col = '0; m_count = 0;

    // Reset
    reset = 1'b0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_hit_overflow", 32'(hit_overflow), 32'd0);
    check("reset_enemy_count", 32'(enemy_count), 32'd0);
    check("reset_wren", 32'(ram_if.wren), 32'd0);
    reset = 1'b1;
    scan_addr = 6'd17;
    step();
    check("idle_rd_follows_scan", 32'(ram_if.rd_addr), 32'd17);

    // Empty table
    run_frame("empty");

    // Single enemy moves down
    bd_write(5, ent(100, 300));
    run_frame("move");
    check("slot5_moved", 32'(mem[5]), 32'({11'd102, 12'd300, 1'b1}));
    check("move_count_one", 32'(enemy_count), 32'd1);

    // Retirement at the row limit
    clear_table();
    bd_write(0, ent(1199, 7));
    run_frame("retire");
    check("slot0_retired", 32'(mem[0]), 32'd0);
    check("retire_count_zero", 32'(enemy_count), 32'd0);

    // Spawn into the lowest free slot, then no repeat spawn
    for (int i = 0; i < 3; i++) bd_write(i, ent(10 + i, 20 + i));
    do_spawn(12'h2A0);
    run_frame("spawn");
    check("slot3_spawned", 32'(mem[3]), 32'({11'h080, 12'h2A0, 1'b1}));
    run_frame("spawn_consumed");

    // Hit queue overflow
    clear_table();
    for (int i = 1; i <= 5; i++) bd_write(i, ent(200, i));
    for (int i = 1; i <= 5; i++) do_hit(i);
    check("hit_overflow_set", 32'(hit_overflow), 32'(m_ovf));
    run_frame("hits");
    check("slot5_survives", 32'(mem[5][0]), 32'd1);

    // Abort in MOVE at entry 10; spawn must survive to the next frame
    for (int i = 0; i < 21; i++) bd_write(i, ent(i * 50, i));
    bd_write(12, 24'h0);
    do_spawn(12'h155);
    run_abort(10);
    run_frame("after_abort");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int nh;
      for (int j = 0; j < 16; j++) begin
        int a, r;
        a = int'($urandom_range(0, 63));
        r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1190, 2047))
                                         : int'($urandom_range(0, 1197));
        if ($urandom_range(0, 4) == 0) bd_write(a, 24'h0);
        else bd_write(a, ent(r, int'($urandom_range(0, 4095))));
      end
      nh = int'($urandom_range(0, 5));
      for (int j = 0; j < nh; j++) do_hit(int'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) do_spawn(12'($urandom_range(0, 4095)));
      check("rand_hit_overflow", 32'(hit_overflow), 32'(m_ovf));
      run_frame("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_enemy_update_sequencer
`default_nettype wire
